// File: rtl/ahblite_adc_sampler.sv
// Multi-channel AHB-lite ADC capture peripheral: round-robin sampling at a
// programmable rate into a tagged-sample FIFO drained through the DATA register.
module ahblite_adc_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           RSTn,
  input  logic                           HSEL,
  input  logic [31:0]                    HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HSIZE,
  input  logic [3:0]                     HPROT,
  input  logic                           HWRITE,
  input  logic [31:0]                    HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic [31:0]                    HRDATA,
  output logic                           HRESP,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic                           IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 4 + DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // Bus address-phase capture
  logic       sel_q, sel_d;
  logic       write_q, write_d;
  logic [1:0] addr_q, addr_d;

  // Control/status registers
  logic                 en_q, en_d;
  logic                 irq_en_q, irq_en_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           thresh_q, thresh_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q, irq_d;

  // Sample timing and channel scan
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [2:0]           ptr_q, ptr_d;

  // FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic                  wr_ctrl, wr_div, wr_stat, rd_data;
  logic                  empty, full, tick, push_req, push_ok, pop, flush, thr_hit;
  logic [CHANNELS-1:0]   eff_mask;
  logic [2:0]            low_ch, cur_ch, nxt_ch;
  logic                  cur_ok, nxt_ok;
  logic [DATA_WIDTH-1:0] cur_sample;
  logic [EW-1:0]         rd_entry;
  logic [23:0]           samp_ext;
  logic [7:0]            count8;
  logic                  unused_bits;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = irq_q;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA};

  assign wr_ctrl = sel_q & write_q & (addr_q == 2'd0);
  assign wr_div  = sel_q & write_q & (addr_q == 2'd1);
  assign wr_stat = sel_q & write_q & (addr_q == 2'd2);
  assign rd_data = sel_q & ~write_q & (addr_q == 2'd3);

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign eff_mask = mask_q[CHANNELS-1:0];
  assign tick     = en_q & (presc_q == div_q);
  assign push_req = tick & (|eff_mask);
  assign pop      = rd_data & ~empty;
  assign flush    = wr_ctrl & HWDATA[1];
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign push_ok  = push_req & ~flush & (~full | pop);

  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    count8 = '0;
    count8[AW:0] = count_q;
    samp_ext = '0;
    samp_ext[DATA_WIDTH-1:0] = rd_entry[DATA_WIDTH-1:0];
  end

  assign thr_hit = (thresh_q != 8'd0) & (count8 >= thresh_q);

  // Channel scan: sample the first enabled channel at or after ptr (wrapping),
  // then point at the next enabled channel after the one sampled.
  always_comb begin
    low_ch = '0;
    cur_ch = '0;
    nxt_ch = '0;
    cur_ok = 1'b0;
    nxt_ok = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (eff_mask[j]) low_ch = 3'(j);
    end
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (eff_mask[j] && (j >= int'(ptr_q))) begin
        cur_ch = 3'(j);
        cur_ok = 1'b1;
      end
    end
    if (!cur_ok) cur_ch = low_ch;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (eff_mask[j] && (j > int'(cur_ch))) begin
        nxt_ch = 3'(j);
        nxt_ok = 1'b1;
      end
    end
    if (!nxt_ok) nxt_ch = low_ch;
  end

  always_comb begin
    cur_sample = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (cur_ch == 3'(j)) cur_sample = data_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    sel_d    = HSEL & HTRANS[1] & HREADY;
    write_d  = HWRITE;
    addr_d   = HADDR[3:2];
    en_d     = en_q;
    irq_en_d = irq_en_q;
    mask_d   = mask_q;
    thresh_d = thresh_q;
    div_d    = div_q;
    presc_d  = presc_q;
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_d    = irq_en_q & (thr_hit | ovf_q);

    if (wr_ctrl) begin
      en_d     = HWDATA[0];
      irq_en_d = HWDATA[2];
      mask_d   = HWDATA[15:8];
      thresh_d = HWDATA[31:24];
    end
    if (wr_div) div_d = HWDATA[DIV_WIDTH-1:0];

    if (!en_q) begin
      presc_d = '0;
      ptr_d   = '0;
    end else begin
      if (wr_div || tick) presc_d = '0;
      else                presc_d = presc_q + DIV_WIDTH'(1);
      if (push_req) ptr_d = nxt_ch;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // A new overflow wins over a same-cycle W1C so it is never lost.
    if (push_req && full && !pop && !flush) ovf_d = 1'b1;
    else if (wr_stat && HWDATA[2])          ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sel_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      mask_q   <= '0;
      thresh_q <= '0;
      div_q    <= '0;
      presc_q  <= '0;
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      mask_q   <= mask_d;
      thresh_q <= thresh_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {1'b0, cur_ch, cur_sample};
  end

  always_comb begin
    HRDATA = '0;
    if (sel_q && !write_q) begin
      case (addr_q)
        2'd0: HRDATA = {thresh_q, 8'h00, mask_q, 5'b0, irq_en_q, 1'b0, en_q};
        2'd1: HRDATA[DIV_WIDTH-1:0] = div_q;
        2'd2: begin
          HRDATA[0]    = empty;
          HRDATA[1]    = full;
          HRDATA[2]    = ovf_q;
          HRDATA[3]    = thr_hit;
          HRDATA[15:8] = count8;
        end
        default: begin
          if (!empty) HRDATA = {4'b0, rd_entry[EW-1:DATA_WIDTH], samp_ext};
        end
      endcase
    end
  end

endmodule
